// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with per-entry saturating counters.
// Fetch-side lookup is purely combinational; EX-side resolution updates the
// tables and raises a registered one-cycle redirect on mispredict.
// Optional feature macro: BPU_STATS_EN enables the branch/mispredict counters;
// when undefined the counter logic is absent and the stat ports read 0.
module branch_predict_unit #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [31:0]     f_pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [31:0]     ex_imm,
  input  logic [31:0]     ex_alu_result,
  input  logic            ex_branch,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic [31:0]     ex_pc_four,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [31:0] sat32_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [CNT_W-1:0]   r_cnt    [ENTRIES];

  // ---------------- fetch-side lookup ----------------
  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;

  assign w_f_idx       = f_pc[IDX_W+1:2];
  assign w_f_tag       = f_pc[PC_W-1:IDX_W+2];
  assign w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign f_pred_taken  = w_f_hit && r_cnt[w_f_idx][CNT_W-1];
  assign f_pred_target = f_pred_taken ? r_target[w_f_idx] : 32'd0;

  // Low PC bits never participate in indexing (word-aligned fetch).
  logic w_unused_fpc;
  assign w_unused_fpc = ^f_pc[1:0];

  // ---------------- EX-side resolution ----------------
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic [31:0]      w_ex_pc32;
  logic [31:0]      w_taken_target;
  logic [31:0]      w_actual_target;
  logic             w_ctrl;
  logic             w_actual_taken;
  logic             w_resolve;
  logic             w_mispredict;

  assign w_ex_idx   = ex_pc[IDX_W+1:2];
  assign w_ex_tag   = ex_pc[PC_W-1:IDX_W+2];
  assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_pc32  = 32'(ex_pc);
  assign ex_pc_four = w_ex_pc32 + 32'd4;

  assign w_ctrl         = ex_branch | ex_jal | ex_jalr;
  assign w_actual_taken = ex_jal | ex_jalr | (ex_branch & ex_alu_result[0]);
  assign w_taken_target = ex_jalr ? {ex_alu_result[31:1], 1'b0}
                                  : (w_ex_pc32 + ex_imm);
  assign w_actual_target = w_actual_taken ? w_taken_target : ex_pc_four;

  assign w_resolve    = ex_valid & ~ex_stall;
  assign w_mispredict = w_resolve &
                        ((w_actual_taken != ex_pred_taken) ||
                         (w_actual_taken && ex_pred_taken &&
                          (w_taken_target != ex_pred_target)));

  logic w_btb_wr;
  logic w_btb_clr;
  assign w_btb_wr  = w_resolve & w_ctrl & w_actual_taken;
  assign w_btb_clr = w_resolve & ~w_ctrl & ex_pred_taken;

  // Valid bits: set on taken control-flow, cleared by a false hit on non-control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_btb_wr) begin
      r_valid[w_ex_idx] <= 1'b1;
    end else if (w_btb_clr) begin
      r_valid[w_ex_idx] <= 1'b0;
    end
  end

  // Tag/target payload; qualified by r_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= w_taken_target;
    end
  end

  // Direction counters: jumps force strongly-taken; branches train up/down,
  // except a not-taken branch that isn't in the BTB leaves state untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_WEAK_NT;
    end else if (w_resolve) begin
      if (ex_jal || ex_jalr) begin
        r_cnt[w_ex_idx] <= CNT_MAX;
      end else if (ex_branch && w_actual_taken) begin
        r_cnt[w_ex_idx] <= cnt_inc(r_cnt[w_ex_idx]);
      end else if (ex_branch && w_ex_hit) begin
        r_cnt[w_ex_idx] <= cnt_dec(r_cnt[w_ex_idx]);
      end
    end
  end

  // Registered redirect: a one-cycle pulse per mispredicting resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= w_mispredict;
      if (w_mispredict) redirect_pc <= w_actual_target;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_br  <= 32'd0;
      r_stat_mis <= 32'd0;
    end else begin
      if (w_resolve && w_ctrl) r_stat_br  <= sat32_inc(r_stat_br);
      if (w_mispredict)        r_stat_mis <= sat32_inc(r_stat_mis);
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mis;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (default parameters).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        ex_valid, ex_stall;
  logic [8:0]  ex_pc;
  logic [31:0] ex_imm, ex_alu_result;
  logic        ex_branch, ex_jal, ex_jalr;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] ex_pc_four;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predict_unit dut (
    .clk(clk), .reset(reset),
    .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_alu_result(ex_alu_result), .ex_branch(ex_branch), .ex_jal(ex_jal),
    .ex_jalr(ex_jalr), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_pc_four(ex_pc_four),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one EX instruction, let the edge resolve it, sample just after.
  task automatic resolve(input logic [8:0] pc, input logic [31:0] imm,
                         input logic [31:0] alu, input logic br, input logic jl,
                         input logic jr, input logic pt, input logic [31:0] ptg,
                         input logic stall);
    @(negedge clk);
    ex_valid = 1'b1; ex_stall = stall; ex_pc = pc; ex_imm = imm;
    ex_alu_result = alu; ex_branch = br; ex_jal = jl; ex_jalr = jr;
    ex_pred_taken = pt; ex_pred_target = ptg;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    @(negedge clk);
    ex_valid = 1'b0; ex_stall = 1'b0; ex_branch = 1'b0; ex_jal = 1'b0;
    ex_jalr = 1'b0; ex_pred_taken = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic look(input string tag, input logic [8:0] pc,
                      input logic exp_t, input logic [31:0] exp_tg);
    f_pc = pc; #1;
    chk({tag, "_taken"}, 32'(f_pred_taken), 32'(exp_t));
    chk({tag, "_target"}, f_pred_target, exp_tg);
  endtask

  initial begin
    logic [31:0] exp_br, exp_mis;
    reset = 1'b1; f_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0; ex_pc = '0;
    ex_imm = '0; ex_alu_result = '0; ex_branch = 1'b0; ex_jal = 1'b0;
    ex_jalr = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Reset state
    look("rst_lookup", 9'h010, 1'b0, 32'h0);
    chk("rst_redir_v", 32'(redirect_valid), 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'h0);
    chk("rst_stat_br", stat_branches, 32'd0);
    chk("rst_stat_mis", stat_mispredicts, 32'd0);

    // Taken branch, predicted not-taken: redirect to 0x030
    resolve(9'h010, 32'h20, 32'h1, 1, 0, 0, 0, 32'h0, 0);
    chk("br1_redir_v", 32'(redirect_valid), 32'd1);
    chk("br1_redir_pc", redirect_pc, 32'h030);
    chk("br1_pc_four", ex_pc_four, 32'h014);
    idle;
    chk("br1_pulse_end", 32'(redirect_valid), 32'd0);

    // Two more taken resolves, correctly predicted
    resolve(9'h010, 32'h20, 32'h1, 1, 0, 0, 1, 32'h030, 0);
    chk("br2_no_redir", 32'(redirect_valid), 32'd0);
    resolve(9'h010, 32'h20, 32'h1, 1, 0, 0, 1, 32'h030, 0);
    chk("br3_no_redir", 32'(redirect_valid), 32'd0);
    idle;
    look("br_trained", 9'h010, 1'b1, 32'h030);

    // Not-taken twice: counter 3 -> 2 (still taken) -> 1 (not taken)
    resolve(9'h010, 32'h20, 32'h0, 1, 0, 0, 1, 32'h030, 0);
    chk("nt1_redir_v", 32'(redirect_valid), 32'd1);
    chk("nt1_redir_pc", redirect_pc, 32'h014);
    idle;
    look("nt1_lookup", 9'h010, 1'b1, 32'h030);
    resolve(9'h010, 32'h20, 32'h0, 1, 0, 0, 1, 32'h030, 0);
    idle;
    look("nt2_lookup", 9'h010, 1'b0, 32'h0);

    // Not-taken branch missing from BTB: nothing allocated
    resolve(9'h080, 32'h40, 32'h0, 1, 0, 0, 0, 32'h0, 0);
    chk("ntmiss_no_redir", 32'(redirect_valid), 32'd0);
    idle;
    look("ntmiss_lookup", 9'h080, 1'b0, 32'h0);

    // jalr correctly predicted: target bit 0 cleared
    resolve(9'h040, 32'h0, 32'h0000_0105, 0, 0, 1, 1, 32'h104, 0);
    chk("jalr_no_redir", 32'(redirect_valid), 32'd0);
    idle;
    look("jalr_lookup", 9'h040, 1'b1, 32'h104);

    // jal with wrong predicted target
    resolve(9'h010, 32'h100, 32'h0, 0, 1, 0, 1, 32'h030, 0);
    chk("jal_redir_v", 32'(redirect_valid), 32'd1);
    chk("jal_redir_pc", redirect_pc, 32'h110);
    idle;
    look("jal_lookup", 9'h010, 1'b1, 32'h110);

    // Non-control instruction predicted taken
    resolve(9'h010, 32'h0, 32'h0, 0, 0, 0, 1, 32'h110, 0);
    chk("nonctl_redir_v", 32'(redirect_valid), 32'd1);
    chk("nonctl_redir_pc", redirect_pc, 32'h014);
    idle;
    look("nonctl_lookup", 9'h010, 1'b0, 32'h0);

    // Back-to-back mispredicts, second with negative offset
    resolve(9'h100, 32'h8, 32'h1, 1, 0, 0, 0, 32'h0, 0);
    chk("b2b1_redir_v", 32'(redirect_valid), 32'd1);
    chk("b2b1_redir_pc", redirect_pc, 32'h108);
    resolve(9'h180, 32'hFFFF_FFFC, 32'h1, 1, 0, 0, 0, 32'h0, 0);
    chk("b2b2_redir_v", 32'(redirect_valid), 32'd1);
    chk("b2b2_redir_pc", redirect_pc, 32'h17C);
    idle;
    chk("b2b_pulse_end", 32'(redirect_valid), 32'd0);
    look("b2b_lookup", 9'h180, 1'b1, 32'h17C);

    // Stalled mispredicting resolve: no redirect, same index untouched
    resolve(9'h1C0, 32'h4, 32'h1, 1, 0, 0, 0, 32'h0, 1);
    chk("stall_no_redir", 32'(redirect_valid), 32'd0);
    idle;
    look("stall_lookup_new", 9'h1C0, 1'b0, 32'h0);
    look("stall_lookup_old", 9'h180, 1'b1, 32'h17C);

    // Same-cycle lookup and update of one index: pre-update result first
    @(negedge clk);
    f_pc = 9'h0C0;
    ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = 9'h0C0; ex_imm = 32'h10;
    ex_alu_result = 32'h1; ex_branch = 1'b1; ex_jal = 1'b0; ex_jalr = 1'b0;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    #1;
    chk("same_pre_taken", 32'(f_pred_taken), 32'd0);
    @(posedge clk); #1;
    chk("same_post_taken", 32'(f_pred_taken), 32'd1);
    chk("same_post_target", f_pred_target, 32'h0D0);
    chk("same_redir_pc", redirect_pc, 32'h0D0);
    idle;

    // Stats: 11 resolved control instructions, 8 mispredicts so far
`ifdef BPU_STATS_EN
    exp_br = 32'd11; exp_mis = 32'd8;
`else
    exp_br = 32'd0; exp_mis = 32'd0;
`endif
    chk("stat_branches", stat_branches, exp_br);
    chk("stat_mispredicts", stat_mispredicts, exp_mis);

    // Reset between the resolve edge and the pulse being consumed
    resolve(9'h020, 32'h4, 32'h1, 1, 0, 0, 0, 32'h0, 0);
    reset = 1'b1; #1;
    chk("rstmid_redir_v", 32'(redirect_valid), 32'd0);
    chk("rstmid_redir_pc", redirect_pc, 32'h0);
    chk("rstmid_stat_br", stat_branches, 32'd0);
    @(negedge clk);
    reset = 1'b0; ex_valid = 1'b0; ex_branch = 1'b0;
    look("rstmid_lookup", 9'h0C0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("rstmid_no_pulse", 32'(redirect_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
